win7_gen: RTL and testbench
===========================

Name: win7_gen

Overview:
- Window generator for the stereo edge-detection path; the producer end of the 7x7 window interface consumed by the Sobel convolution stage.
- Accepts a raster-order 8-bit pixel stream, buffers 6 prior lines in on-chip RAM, and emits one registered 7x7 pixel window per accepted pixel once a full window exists.
- Streaming, valid-only (no backpressure), matching the convolution stage, which has no ready input.

Parameters:
IMG_W, 640, pixels per line (>=7)
IMG_H, 480, lines per frame (>=7)
DW, 8, pixel width in bits

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
pix_in  in  DW  input pixel
pix_valid  in  1  pix_in accepted on this edge when high
sof  in  1  start of frame; qualifies the pixel accepted with it as (row 0, col 0)
win_out  out  49*DW  window; element (r,c) at bits [(r*7+c)*DW +: DW]; r=0 top/oldest line, c=0 left/oldest column
win_valid  out  1  win_out holds a complete in-frame window
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted
win_x  out  clog2(IMG_W)  window centre column (only with WIN_COORD_EN)
win_y  out  clog2(IMG_H)  window centre row (only with WIN_COORD_EN)

Behaviour:
- Reset (asynchronous assert, synchronous release): col/row counters = 0, win_out = 0, win_valid = 0, frame_done = 0, win_x/win_y = 0. Line-buffer RAM is not reset; valid gating masks stale contents.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1 are the coordinates of the pixel being accepted. On each accepted pixel, col increments. At IMG_W-1, col wraps to 0 and row increments. At (IMG_H-1, IMG_W-1), both wrap to 0.
- sof with pix_valid forces the accepted pixel to (0,0); the counters continue from (0,1). A mid-frame sof aborts the current frame silently: no frame_done, no further windows from the old frame. sof without pix_valid is ignored.
- Line buffers: six lines of IMG_W x DW, addressed by col. On acceptance, the new column {lb5[col] .. lb0[col], pix_in} (top to bottom) shifts into window column 6, and existing columns shift left. The line buffers shift down at address col.
- Output timing: registered, latency 1. If the pixel at (row,col) is accepted on edge N, win_out and win_valid update on edge N+1.
  - win_valid = 1 iff row >= 6 and col >= 6 for that pixel; window centre = (row-3, col-3).
  - Windows straddling a line wrap are never flagged valid.
  - Count per frame: (IMG_W-6)*(IMG_H-6).
- pix_valid low: window, counters, and RAM hold; win_valid = 0 on the next edge; win_out holds its last value.
- frame_done: high for one cycle, one edge after acceptance of (IMG_H-1, IMG_W-1), coincident with the last win_valid.
- Pixels arriving after frame end with no sof start the next frame at (0,0) (implicit wrap).
- Simultaneous sof and frame-end pixel: sof wins. The pixel is treated as (0,0); no frame_done.
- Reset mid-frame: all outputs clear immediately. The next frame restarts at (0,0) regardless of sof.

Optional Feature:
- Macro WIN7_GEN_WIN_COORD_EN.
- Defined: win_x/win_y ports exist, registered alongside win_out, holding the centre (col-3, row-3) of the emitted window. They hold when win_valid = 0 and reset to 0.
- Undefined: the ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Run with IMG_W=8, IMG_H=8; stream 64 pixels with value row*16+col, sof on the first pixel, pix_valid always high.
  -> First win_valid is one cycle after accepting (6,6). That window element (r,c) = r*16+c; exactly 4 windows with centres (3,3),(3,4),(4,3),(4,4). frame_done pulses with the 4th window.
- Repeat the stream with pix_valid low every other cycle.
  -> Identical window contents and count; win_valid never high on the cycle after an idle slot; win_out holds.
- Assert sof again after 30 pixels, then send a full 64-pixel frame.
  -> No frame_done for the aborted frame; exactly 4 valid windows, matching the first test's values.
- Assert rst for 1 cycle mid-frame at (6,7); stream a full frame without sof.
  -> All outputs 0 immediately after reset; 4 correct windows, then frame_done.
- Stream two back-to-back 64-pixel frames with sof only on the first; the second frame's values are offset by 0x80.
  -> 8 windows total, 2 frame_done pulses; second-frame windows contain only second-frame pixels.
- With WIN7_GEN_WIN_COORD_EN defined, rerun the first test.
  -> win_x/win_y = (3,3),(4,3),(3,4),(4,4) in emission order, aligned with win_valid.

Source files
------------

// File: rtl/win7_gen.sv
// win7_gen: 7x7 sliding-window generator over a raster 8-bit pixel stream.
//   Buffers six prior lines and emits one registered 7x7 window per accepted
//   pixel once a full window exists (latency 1 edge, no backpressure).
//   Ports: clk, rst (async active-high), pix_in/pix_valid/sof (input stream),
//   win_out/win_valid (window, element (r,c) at [(r*7+c)*DW +: DW]),
//   frame_done (pulse with the last window of a frame),
//   win_x/win_y (window centre; only when WIN7_GEN_WIN_COORD_EN is defined).
module win7_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DW-1:0]            pix_in,
  input  logic                     pix_valid,
  input  logic                     sof,
  output logic [49*DW-1:0]         win_out,
  output logic                     win_valid,
  output logic                     frame_done
`ifdef WIN7_GEN_WIN_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0] win_x,
  output logic [$clog2(IMG_H)-1:0] win_y
`endif
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  logic [CW-1:0]      col_q, col_d, ecol, a1_q;
  logic [RW-1:0]      row_q, row_d, erow;
  logic               col_end, row_end, wv_d, fd_d;
  logic               v1_q, wv1_q, fd1_q;
  logic [DW-1:0]      px1_q;
  logic [DW-1:0]      rd_q [6];
  logic [DW-1:0]      lb [6][IMG_W];
  logic [49*DW-1:0]   win_q, win_d;
  logic               win_valid_q, frame_done_q;
`ifdef WIN7_GEN_WIN_COORD_EN
  logic [CW-1:0]      cx1_q, x_q;
  logic [RW-1:0]      cy1_q, y_q;
  assign win_x = x_q;
  assign win_y = y_q;
`endif
  assign win_out    = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  // sof relocates the accepted pixel to (0,0); a frame-end pixel carrying sof
  // therefore never raises frame_done.
  always_comb begin
    ecol    = sof ? '0 : col_q;
    erow    = sof ? '0 : row_q;
    col_end = ecol == CW'(IMG_W - 1);
    row_end = erow == RW'(IMG_H - 1);
    col_d   = col_end ? '0 : ecol + CW'(1);
    row_d   = col_end ? (row_end ? '0 : erow + RW'(1)) : erow;
    wv_d    = erow >= RW'(6) && ecol >= CW'(6);
    fd_d    = col_end && row_end;
  end
  // Window shifts left; column 6 takes {lb5..lb0, pixel} top to bottom.
  always_comb begin
    win_d = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        win_d[(r*7+c)*DW +: DW] = (c < 6) ? win_q[(r*7+c+1)*DW +: DW]
                                : (r == 6) ? px1_q : rd_q[5-r];
  end
  // Line buffers: registered read on acceptance, shift-down write one edge
  // later at the same address. Consecutive accepted pixels always differ in
  // column, so the read never needs the pending write.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      for (int k = 0; k < 6; k++) rd_q[k] <= lb[k][ecol];
      a1_q  <= ecol;
      px1_q <= pix_in;
    end
    if (v1_q) begin
      lb[0][a1_q] <= px1_q;
      for (int k = 1; k < 6; k++) lb[k][a1_q] <= rd_q[k-1];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      v1_q         <= 1'b0;
      wv1_q        <= 1'b0;
      fd1_q        <= 1'b0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef WIN7_GEN_WIN_COORD_EN
      cx1_q        <= '0;
      cy1_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
`endif
    end else begin
      v1_q         <= pix_valid;
      wv1_q        <= pix_valid && wv_d;
      fd1_q        <= pix_valid && fd_d;
      win_valid_q  <= wv1_q;
      frame_done_q <= fd1_q;
      if (pix_valid) begin
        col_q <= col_d;
        row_q <= row_d;
      end
      if (v1_q) win_q <= win_d;
`ifdef WIN7_GEN_WIN_COORD_EN
      if (pix_valid) begin
        cx1_q <= ecol - CW'(3);
        cy1_q <= erow - RW'(3);
      end
      if (wv1_q) begin
        x_q <= cx1_q;
        y_q <= cy1_q;
      end
`endif
    end
  end
endmodule

// File: tb/tb_win7_gen.sv
// tb_win7_gen: scoreboard bench for win7_gen on an 8x8 image.
module tb_win7_gen;
  localparam int WW = 49 * 8;
  typedef struct {
    logic [WW-1:0] w;
    logic          fd;
    int            x;
    int            y;
  } exp_t;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    pix_in = '0;
  logic          pix_valid = 1'b0;
  logic          sof = 1'b0;
  logic [WW-1:0] win_out;
  logic          win_valid, frame_done;
`ifdef WIN7_GEN_WIN_COORD_EN
  logic [2:0]    win_x, win_y;
`endif
  int            checks = 0, failures = 0, nwin = 0, nfd = 0;
  exp_t          q[$];
  exp_t          e;
  logic [WW-1:0] last_w = '0;
  bit            lastv = 0;
  logic          acc1 = 1'b0, acc2 = 1'b0;

  win7_gen #(.IMG_W(8), .IMG_H(8), .DW(8)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .win_out(win_out), .win_valid(win_valid), .frame_done(frame_done)
`ifdef WIN7_GEN_WIN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [WW-1:0] got, logic [WW-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [WW-1:0] mkwin(int base, int row, int col);
    logic [WW-1:0] w;
    w = '0;
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7; j++)
        w[(i*7+j)*8 +: 8] = 8'(base + (row - 6 + i) * 16 + (col - 6 + j));
    return w;
  endfunction

  // acc2 at a negedge = pix_valid at the edge before the one just taken
  always @(posedge clk or posedge rst)
    if (rst) begin
      acc1 <= 1'b0;
      acc2 <= 1'b0;
    end else begin
      acc1 <= pix_valid;
      acc2 <= acc1;
    end

  always @(negedge clk) begin
    if (!rst) begin
      if (!acc2) check("idle_nv", win_valid, 0);
      if (win_valid) begin
        if (q.size() == 0) check("spurious_win", win_valid, 0);
        else begin
          e = q.pop_front();
          check("win", win_out, e.w);
          check("fd_align", frame_done, e.fd);
`ifdef WIN7_GEN_WIN_COORD_EN
          check("win_x", win_x, e.x);
          check("win_y", win_y, e.y);
`endif
          last_w = e.w;
          lastv  = 1;
          nwin++;
        end
      end else begin
        check("fd_nv", frame_done, 0);
        if (!acc2 && lastv) check("hold", win_out, last_w);
        if (acc2) lastv = 0;
      end
      if (frame_done) nfd++;
    end
  end

  task automatic drive(int base, int r, int c, bit s);
    exp_t ne;
    pix_in    = 8'(base + r * 16 + c);
    pix_valid = 1'b1;
    sof       = s;
    if (r >= 6 && c >= 6) begin
      ne.w  = mkwin(base, r, c);
      ne.fd = (r == 7 && c == 7);
      ne.x  = c - 3;
      ne.y  = r - 3;
      q.push_back(ne);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic frame(int base, bit gap, bit s0, int npix);
    for (int n = 0; n < npix; n++) begin
      drive(base, n / 8, n % 8, s0 && n == 0);
      if (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic start();
    nwin = 0;
    nfd  = 0;
  endtask

  task automatic drain_check(string tag, int ew, int ef);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_nwin"}, nwin, ew);
    check({tag, "_nfd"}, nfd, ef);
    check({tag, "_qempty"}, q.size(), 0);
  endtask

  initial begin
    #3;
    check("rst_win", win_out, 0);
    check("rst_valid", win_valid, 0);
    check("rst_fd", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    start(); frame(0, 0, 1, 64); drain_check("basic", 4, 1);
    start(); frame(0, 1, 1, 64); drain_check("gap", 4, 1);
    start(); frame(0, 0, 1, 30); frame(0, 0, 1, 64); drain_check("abort", 4, 1);
    start(); frame(0, 0, 1, 55);
    rst = 1'b1;
    q.delete();
    #1;
    check("mrst_win", win_out, 0);
    check("mrst_valid", win_valid, 0);
    check("mrst_fd", frame_done, 0);
    @(posedge clk); #1;
    rst   = 1'b0;
    lastv = 0;
    start(); frame(0, 0, 0, 64); drain_check("after_rst", 4, 1);
    start(); frame(0, 0, 1, 64); frame(128, 0, 0, 64); drain_check("b2b", 8, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
